pipe_add_sub: RTL and testbench

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

---
 rtl/pipe_add_sub.sv | 151 +++++++++++++++
 tb/tb_pipe_add_sub.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_sub.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_add_sub
// Brief    : Elastic pipelined adder/subtractor, one WIDTH/STAGES-bit slice per
//            stage with a registered ripple carry between stages.
//            Optional macro PIPE_ADD_SUB_SATURATE_EN clamps on signed overflow.
// Revision : 1.0
//------------------------------------------------------------------------------
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int c_SLICE_W = WIDTH / STAGES;

  logic [WIDTH-1:0]  w_bEff;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_load;
  logic              w_down;

  assign w_bEff = sub ? ~b : b;

  // A stage loads when empty or when whatever sits downstream of it moves on.
  always_comb begin
    w_load = '0;
    w_down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_load[k] = !w_valid[k] || w_down;
      w_down    = w_load[k];
    end
  end

  assign in_ready = w_load[0];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic                 r_valid;
      logic                 r_carry;
      logic [WIDTH-1:0]     r_word;
      logic                 w_inValid;
      logic                 w_inCarry;
      logic [WIDTH-1:0]     w_inWord;
      logic [c_SLICE_W-1:0] w_bSlice;
      logic [c_SLICE_W:0]   w_slice;
      logic [WIDTH-1:0]     w_nextWord;
      logic [WIDTH-1:0]     w_storeWord;

      // r_word carries finished result slices below and untouched a slices above.
      if (k == 0) begin : g_head
        assign w_inValid = in_valid;
        assign w_inCarry = sub;
        assign w_inWord  = a;
        assign w_bSlice  = w_bEff[c_SLICE_W-1:0];
      end else begin : g_body
        assign w_inValid = g_stage[k-1].r_valid;
        assign w_inCarry = g_stage[k-1].r_carry;
        assign w_inWord  = g_stage[k-1].r_word;
        assign w_bSlice  = g_stage[k-1].g_mid.r_opBHi[k*c_SLICE_W +: c_SLICE_W];
      end

      assign w_slice = {1'b0, w_inWord[k*c_SLICE_W +: c_SLICE_W]}
                     + {1'b0, w_bSlice}
                     + {{c_SLICE_W{1'b0}}, w_inCarry};

      always_comb begin
        w_nextWord = w_inWord;
        w_nextWord[k*c_SLICE_W +: c_SLICE_W] = w_slice[c_SLICE_W-1:0];
      end

      if (k == STAGES - 1) begin : g_last
        logic w_ovf;
        logic r_ovf;

        // Carry into the MSB is recovered as a^b^s at that bit position.
        assign w_ovf = w_inWord[WIDTH-1] ^ w_bSlice[c_SLICE_W-1]
                     ^ w_slice[c_SLICE_W-1] ^ w_slice[c_SLICE_W];

`ifdef PIPE_ADD_SUB_SATURATE_EN
        assign w_storeWord = !w_ovf ? w_nextWord :
                             w_inWord[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
`else
        assign w_storeWord = w_nextWord;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ovf <= 1'b0;
          end else if (w_load[k] && w_inValid) begin
            r_ovf <= w_ovf;
          end
        end
      end else begin : g_mid
        logic [WIDTH-1:(k+1)*c_SLICE_W] r_opBHi;
        logic [WIDTH-1:(k+1)*c_SLICE_W] w_bHiIn;

        assign w_storeWord = w_nextWord;

        if (k == 0) begin : g_first
          assign w_bHiIn = w_bEff[WIDTH-1:c_SLICE_W];
        end else begin : g_next
          assign w_bHiIn = g_stage[k-1].g_mid.r_opBHi[WIDTH-1:(k+1)*c_SLICE_W];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_opBHi <= '0;
          end else if (w_load[k] && w_inValid) begin
            r_opBHi <= w_bHiIn;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_carry <= 1'b0;
          r_word  <= '0;
        end else if (w_load[k]) begin
          r_valid <= w_inValid;
          if (w_inValid) begin
            r_carry <= w_slice[c_SLICE_W];
            r_word  <= w_storeWord;
          end
        end
      end

      assign w_valid[k] = r_valid;
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_word;
  assign carry_out = g_stage[STAGES-1].r_carry;
  assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_add_sub.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pipe_add_sub
// Brief    : Self-checking bench for pipe_add_sub (WIDTH=32, STAGES=4).
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_pipe_add_sub;

`ifdef PIPE_ADD_SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vs;
    logic [31:0] sWrap;
    logic [31:0] sSat;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;

  int   errors = 0;
  int   checks = 0;
  logic sbOn   = 1'b0;
  res_t gotQ[$];
  res_t expQ[$];

  pipe_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Inputs only change 1ns after a rising edge, so a falling-edge sample
  // sees exactly what the next rising edge will see.
  always @(negedge clk) begin
    if (sbOn && rst_n && out_valid && out_ready) gotQ.push_back({sum, carry_out, overflow});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [32:0] full;
    res_t        r;
    full = s ? ({1'b0, x} + {1'b0, ~y} + 33'd1) : ({1'b0, x} + {1'b0, y});
    r.s  = full[31:0];
    r.c  = full[32];
    r.o  = s ? ((x[31] != y[31]) && (full[31] != x[31]))
             : ((x[31] == y[31]) && (full[31] != x[31]));
    if (SAT && r.o) r.s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return r;
  endfunction

  // Present one operation to an idle pipeline and wait (bounded) for its result.
  task automatic applyOne(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                          output res_t r, output int lat);
    a = va; b = vb; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = {sum, carry_out, overflow};
    @(posedge clk); #1;
  endtask

  vec_t vecs[11];
  res_t r;
  int   lat;
  int   base;
  int   idx;
  int   nAcc;
  int   accepts;
  logic readyAt9;
  logic stallOk;
  logic haveHeld;
  logic [31:0] heldSum;
  logic [31:0] firstHeld;
  logic pending;
  logic [31:0] ra, rb;
  logic rs;

  initial begin
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0};
    vecs[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[10] = '{32'h0000_FF00, 32'h0000_0100, 1'b1, 32'h0000_FE00, 32'h0000_FE00, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset carry_out", 64'(carry_out), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);

    // Directed single operations on an idle pipeline.
    for (int i = 0; i < 11; i++) begin
      applyOne(vecs[i].va, vecs[i].vb, vecs[i].vs, r, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
      check($sformatf("vec%0d sum", i), 64'(r.s), 64'(SAT ? vecs[i].sSat : vecs[i].sWrap));
      check($sformatf("vec%0d carry_out", i), 64'(r.c), 64'(vecs[i].c));
      check($sformatf("vec%0d overflow", i), 64'(r.o), 64'(vecs[i].o));
    end

    // Eight back-to-back i+i with the sink stalled for the first 10 cycles.
    sbOn = 1'b1;
    base = gotQ.size();
    expQ.delete();
    idx = 1; accepts = 0; readyAt9 = 1'b1; stallOk = 1'b1; haveHeld = 1'b0;
    heldSum = '0; firstHeld = '0;
    for (int cyc = 0; cyc < 120 && (gotQ.size() - base) < 8; cyc++) begin
      out_ready = (cyc >= 10);
      in_valid  = (idx <= 8);
      a = 32'(idx); b = 32'(idx); sub = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        expQ.push_back({32'(2 * idx), 1'b0, 1'b0});
        idx++;
      end
      if (cyc == 9) begin
        accepts  = idx - 1;
        readyAt9 = in_ready;
      end
      if (!out_ready && out_valid) begin
        if (!haveHeld) firstHeld = sum;
        else if (sum !== heldSum) stallOk = 1'b0;
        heldSum  = sum;
        haveHeld = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall accepts", 64'(accepts), 64'd4);
    check("stall in_ready", 64'(readyAt9), 64'd0);
    check("stall out_valid seen", 64'(haveHeld), 64'd1);
    check("stall held sum", 64'(firstHeld), 64'd2);
    check("stall sum stable", 64'(stallOk), 64'd1);
    check("stall count", 64'(gotQ.size() - base), 64'd8);
    for (int i = 0; i < 8 && (base + i) < gotQ.size(); i++)
      check($sformatf("stall result%0d", i), 64'(gotQ[base + i]), 64'(expQ[i]));

    // Random operands with a randomly stalling sink.
    base = gotQ.size();
    expQ.delete();
    nAcc = 0; pending = 1'b0; ra = '0; rb = '0; rs = 1'b0;
    for (int cyc = 0; cyc < 20000 && (gotQ.size() - base) < 1000; cyc++) begin
      if (!pending && nAcc < 1000) begin
        pending = ($urandom_range(0, 3) != 0);
        ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      end
      in_valid  = pending;
      a = ra; b = rb; sub = rs;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        expQ.push_back(model(ra, rb, rs));
        nAcc++;
        pending = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("random count", 64'(gotQ.size() - base), 64'd1000);
    for (int i = 0; i < expQ.size() && (base + i) < gotQ.size(); i++)
      check($sformatf("random result%0d", i), 64'(gotQ[base + i]), 64'(expQ[i]));

    // Reset with three operations in flight, the oldest stalled at the output.
    out_ready = 1'b0; nAcc = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = (nAcc < 3);
      a = 32'(100 + nAcc); b = 32'd1; sub = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) nAcc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    base = gotQ.size();
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset sum", 64'(sum), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("in_ready at release", 64'(in_ready), 64'd1);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
    end
    check("flushed ops emitted", 64'(gotQ.size() - base), 64'd0);
    applyOne(32'h0000_0010, 32'h0000_0020, 1'b0, r, lat);
    check("post-reset latency", 64'(lat), 64'd4);
    check("post-reset result", 64'(r), 64'({32'h0000_0030, 1'b0, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
